// File: rtl/dfir_multichan.sv
// dfir_multichan: I/O-mapped multi-channel FIR peripheral with one sequential MAC.
// Coefficients are shared by all channels; per-channel circular delay lines share one sample RAM.
module dfir_multichan #(
    parameter int TAPS = 128,
    parameter int DW   = 16,
    parameter int CW   = 18,
    parameter int NCH  = 2,
    localparam int AW  = DW + CW + $clog2(TAPS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ioaddr,
    input  logic        iocs,
    input  logic [15:0] din,
    input  logic        iowr,
    input  logic        iord,
    output logic [15:0] dout,
    output logic        busy
);

    localparam int TW  = $clog2(TAPS);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW1 = AW + 1;
    localparam logic signed [AW:0] SMAX = AW1'(32767);
    localparam logic signed [AW:0] SMIN = AW1'(-32768);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, CLR} state_t;
    state_t state, state_nxt;

    logic signed [CW-1:0] coef_ram [TAPS];
    logic signed [DW-1:0] samp_ram [NCH*TAPS];
    logic signed [15:0]   result   [NCH];
    logic [TW-1:0]        ptr      [NCH];

    logic [CHW-1:0]       chsel, ch_job;
    logic [TW-1:0]        caddr, k, lastn, nm1_in, ptr_nxt, rd_idx;
    logic [5:0]           shift;
    logic [1:0]           dcnt;
    logic                 done, sat, err;
    logic                 mac_run, drain_run, clr_run, fin;
    logic                 wr, rd, start_w, push_w, coef_w;
    logic                 start_acc, push_acc, coef_acc;
    logic                 samp_we;
    logic [CHW+TW-1:0]    samp_wa;
    logic signed [DW-1:0] samp_wd;
    logic                 vld_p0, vld_p1;
    logic signed [CW-1:0]    c_p0;
    logic signed [DW-1:0]    x_p0;
    logic signed [DW+CW-1:0] prod_p1;
    logic signed [AW-1:0]    acc;
    logic [16:0]             fin_val;

    function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] a,
                                                       input logic [5:0] sh);
        logic signed [AW:0] s;
        s = AW1'(a);
        if (sh != 6'd0)
            s = s + (AW1'(1) <<< (sh - 6'd1));
        return s >>> sh;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [16:0] sat16(input logic signed [AW:0] v);
        if (v > SMAX) return {1'b1, 16'h7fff};
        if (v < SMIN) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    assign wr        = iocs & iowr;
    assign rd        = iocs & iord;
    assign start_w   = wr && (ioaddr == 3'd2);
    assign push_w    = wr && (ioaddr == 3'd0);
    assign coef_w    = wr && (ioaddr == 3'd4);
    assign start_acc = start_w && (state == IDLE);
    assign push_acc  = push_w  && (state == IDLE);
    assign coef_acc  = coef_w  && (state == IDLE);
    assign nm1_in    = (din[15:8] > 8'(TAPS - 1)) ? TW'(TAPS - 1) : din[8 +: TW];
    assign ptr_nxt   = ptr[chsel] + TW'(1);
    assign rd_idx    = ptr[ch_job] - k;
    assign fin_val   = sat16(round_shift(acc, shift));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = din[0] ? CLR : MAC;
            MAC:     if (k == lastn) state_nxt = DRAIN;
            DRAIN:   if (dcnt == 2'd2) state_nxt = IDLE;
            CLR:     if (k == TW'(TAPS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mac_run   = (state == MAC);
        drain_run = (state == DRAIN);
        clr_run   = (state == CLR);
        fin       = drain_run && (dcnt == 2'd2);
    end

    always_comb begin
        samp_we = push_acc;
        samp_wa = {chsel, ptr_nxt};
        samp_wd = DW'($signed(din));
        if (clr_run) begin
            samp_we = 1'b1;
            samp_wa = {ch_job, k};
            samp_wd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chsel  <= '0;
            caddr  <= '0;
            shift  <= 6'd15;
            done   <= 1'b0;
            sat    <= 1'b0;
            err    <= 1'b0;
            lastn  <= '0;
            ch_job <= '0;
            k      <= '0;
            dcnt   <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            acc    <= '0;
            dout   <= '0;
            for (int i = 0; i < NCH; i++) ptr[i] <= '0;
        end else begin
            vld_p0 <= mac_run;
            vld_p1 <= vld_p0;
            if (vld_p1) acc <= acc + AW'(prod_p1);
            if (mac_run || clr_run) k <= k + TW'(1);
            if (mac_run)   dcnt <= '0;
            if (drain_run) dcnt <= dcnt + 2'd1;

            if (wr && ioaddr == 3'd1) chsel <= (NCH > 1) ? din[CHW-1:0] : '0;
            if (wr && ioaddr == 3'd3) shift <= (din[5:0] > 6'(AW - 1)) ? 6'(AW - 1) : din[5:0];
            if (wr && ioaddr == 3'd5) caddr <= din[TW-1:0];
            if (coef_acc) caddr <= caddr + TW'(1);
            if (push_acc) ptr[chsel] <= ptr_nxt;
            if (busy && (start_w || push_w || coef_w)) err <= 1'b1;

            if (start_acc) begin
                err    <= 1'b0;
                lastn  <= nm1_in;
                ch_job <= chsel;
                k      <= '0;
                if (din[0]) begin
                    ptr[chsel] <= '0;
                end else begin
                    sat <= 1'b0;
                    acc <= '0;
                end
            end

            if (rd && ioaddr == 3'd0) done <= 1'b0;
            if (fin) begin
                done <= 1'b1;
                sat  <= fin_val[16];
            end

            if (rd) begin
                case (ioaddr)
                    3'd0:    dout <= result[chsel];
                    3'd1:    dout <= 16'(chsel);
                    3'd2:    dout <= {busy, done, sat, err, 4'b0, 8'(lastn)};
                    3'd3:    dout <= 16'(shift);
                    3'd5:    dout <= 16'(caddr);
                    default: dout <= '0;
                endcase
            end
        end
    end

    // Stage p0 reads RAMs, p1 multiplies; accumulation happens in acc above.
    always_ff @(posedge clk) begin
        if (coef_acc) coef_ram[caddr] <= CW'($signed(din));
        if (samp_we)  samp_ram[samp_wa] <= samp_wd;
        c_p0    <= coef_ram[k];
        x_p0    <= samp_ram[{ch_job, rd_idx}];
        prod_p1 <= c_p0 * x_p0;
        if (fin) result[ch_job] <= fin_val[15:0];
    end

endmodule
